// File: rtl/regfile_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_dbg_arbiter
//
// Purpose:
//   Shares the 16x8 CPU register file between the CPU datapath and a debug
//   monitor (UART/JTAG bridge). The block sits between the core's register-file
//   control outputs and the register file's inputs.
//
//   When the debug side raises dbg_req, the core is asked to freeze (stall).
//   Once the core reports cpu_stalled, one debug read or write is performed in
//   a single stolen cycle. The access is then acknowledged with a one-cycle
//   dbg_ack pulse and the core is released. If the core does not quiesce
//   within WAIT_LIMIT cycles, the request is acknowledged with dbg_err=1 and
//   no register-file access takes place.
//
// Parameters:
//   WAIT_LIMIT  max cycles spent waiting for cpu_stalled before an error ack;
//               0 disables the timeout (wait indefinitely)
//   CNT_W       width of the wait counter; must be able to hold WAIT_LIMIT
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   rst_n          in   synchronous active-low reset
//   cpu_inSelect   in   [3:0] core write / outA register select
//   cpu_outBselect in   [3:0] core outB / pair select
//   cpu_in         in   [7:0] core write data
//   cpu_write_en   in   core write strobe
//   cpu_inc        in   core pair-increment strobe
//   cpu_dec        in   core pair-decrement strobe
//   cpu_stalled    in   core has frozen in response to stall (level)
//   stall          out  request core to freeze
//   rf_inSelect    out  [3:0] to register file
//   rf_outBselect  out  [3:0] to register file
//   rf_in          out  [7:0] to register file
//   rf_write_en    out  to register file
//   rf_inc         out  to register file
//   rf_dec         out  to register file
//   rf_outB        in   [7:0] register file outB (combinational read data)
//   dbg_req        in   debug access request, held high until dbg_ack
//   dbg_we         in   1=write, 0=read; stable while dbg_req is high
//   dbg_addr       in   [3:0] register index; stable while dbg_req is high
//   dbg_wdata      in   [7:0] write data; stable while dbg_req is high
//   dbg_ack        out  one-cycle completion pulse
//   dbg_err        out  valid with dbg_ack: 1=timeout, no access performed
//   dbg_rdata      out  [7:0] read data, valid from dbg_ack, held until the
//                       next successful read
// -----------------------------------------------------------------------------
module regfile_dbg_arbiter #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  // core side
  input  logic [3:0] cpu_inSelect,
  input  logic [3:0] cpu_outBselect,
  input  logic [7:0] cpu_in,
  input  logic       cpu_write_en,
  input  logic       cpu_inc,
  input  logic       cpu_dec,
  input  logic       cpu_stalled,
  output logic       stall,
  // register-file side
  output logic [3:0] rf_inSelect,
  output logic [3:0] rf_outBselect,
  output logic [7:0] rf_in,
  output logic       rf_write_en,
  output logic       rf_inc,
  output logic       rf_dec,
  input  logic [7:0] rf_outB,
  // debug side
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [3:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_ack,
  output logic       dbg_err,
  output logic [7:0] dbg_rdata
);

  // The two acknowledge flavours are separate states so that dbg_ack and
  // dbg_err are decoded purely from the state register.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_ACK_OK  = 3'd3,
    ST_ACK_ERR = 3'd4
  } state_e;

  localparam bit             TIMEOUT_EN = (WAIT_LIMIT != 0);
  // Last count value before giving up; only meaningful when TIMEOUT_EN is set.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       rdata_q, rdata_d;

  // Saturating increment: the wait counter must never wrap while waiting,
  // otherwise a disabled or large timeout could alias back to a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // State, wait counter and read-data holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg_req) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!dbg_req) begin
          // Requester withdrew: abort silently, no ack.
          state_d = ST_IDLE;
        end else if (cpu_stalled) begin
          state_d = ST_ACCESS;
        end else if (TIMEOUT_EN && (cnt_q == LIMIT_M1)) begin
          state_d = ST_ACK_ERR;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = sat_inc(cnt_q);
        end
      end
      ST_ACCESS: begin
        // The access always completes once started, whatever cpu_stalled does.
        state_d = ST_ACK_OK;
      end
      ST_ACK_OK: begin
        state_d = ST_IDLE;
      end
      ST_ACK_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Unreachable encodings recover to a safe idle.
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Read data is captured from the register file at the end of a read ACCESS
  // cycle and otherwise held, so timeouts and writes leave it untouched.
  always_comb begin
    if ((state_q == ST_ACCESS) && !dbg_we) begin
      rdata_d = rf_outB;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output decode: stall/ack/err and the register-file mux from state only.
  always_comb begin
    stall         = 1'b0;
    dbg_ack       = 1'b0;
    dbg_err       = 1'b0;
    rf_inSelect   = cpu_inSelect;
    rf_outBselect = cpu_outBselect;
    rf_in         = cpu_in;
    rf_write_en   = cpu_write_en;
    rf_inc        = cpu_inc;
    rf_dec        = cpu_dec;
    case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
      end
      ST_WAIT: begin
        // Core still owns the register file; it may be finishing an instruction.
        stall = 1'b1;
      end
      ST_ACCESS: begin
        stall         = 1'b1;
        rf_inSelect   = dbg_addr;
        rf_outBselect = dbg_addr;
        rf_inc        = 1'b0;
        rf_dec        = 1'b0;
        if (dbg_we) begin
          rf_in       = dbg_wdata;
          rf_write_en = 1'b1;
        end else begin
          rf_in       = 8'h00;
          rf_write_en = 1'b0;
        end
      end
      ST_ACK_OK: begin
        stall         = 1'b1;
        dbg_ack       = 1'b1;
        dbg_err       = 1'b0;
        rf_inSelect   = dbg_addr;
        rf_outBselect = dbg_addr;
        rf_in         = 8'h00;
        rf_write_en   = 1'b0;
        rf_inc        = 1'b0;
        rf_dec        = 1'b0;
      end
      ST_ACK_ERR: begin
        stall         = 1'b1;
        dbg_ack       = 1'b1;
        dbg_err       = 1'b1;
        rf_inSelect   = dbg_addr;
        rf_outBselect = dbg_addr;
        rf_in         = 8'h00;
        rf_write_en   = 1'b0;
        rf_inc        = 1'b0;
        rf_dec        = 1'b0;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_dbg_arbiter
//
// Self-checking bench for regfile_dbg_arbiter. A small register file is
// modelled around the DUT (written from the rf_* outputs, read through
// rf_outB). A cycle-level reference model computes the expected outputs from
// the arbitration rules and keeps its own copy of the register contents; every
// cycle the DUT outputs are compared against it. Directed scenarios add
// hand-computed literal expectations, then a randomized phase runs traffic.
// -----------------------------------------------------------------------------
module tb_regfile_dbg_arbiter;

  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cpu_inSelect = 4'h0;
  logic [3:0] cpu_outBselect = 4'h0;
  logic [7:0] cpu_in = 8'h00;
  logic       cpu_write_en = 1'b0;
  logic       cpu_inc = 1'b0;
  logic       cpu_dec = 1'b0;
  logic       cpu_stalled = 1'b0;
  logic       stall;
  logic [3:0] rf_inSelect;
  logic [3:0] rf_outBselect;
  logic [7:0] rf_in;
  logic       rf_write_en;
  logic       rf_inc;
  logic       rf_dec;
  logic [7:0] rf_outB;
  logic       dbg_req = 1'b0;
  logic       dbg_we = 1'b0;
  logic [3:0] dbg_addr = 4'h0;
  logic [7:0] dbg_wdata = 8'h00;
  logic       dbg_ack;
  logic       dbg_err;
  logic [7:0] dbg_rdata;

  always #5 clk = ~clk;

  regfile_dbg_arbiter #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_inSelect(cpu_inSelect), .cpu_outBselect(cpu_outBselect),
    .cpu_in(cpu_in), .cpu_write_en(cpu_write_en), .cpu_inc(cpu_inc),
    .cpu_dec(cpu_dec), .cpu_stalled(cpu_stalled), .stall(stall),
    .rf_inSelect(rf_inSelect), .rf_outBselect(rf_outBselect), .rf_in(rf_in),
    .rf_write_en(rf_write_en), .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_outB(rf_outB),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .dbg_rdata(dbg_rdata)
  );

  // Environment register file driven by the DUT's rf_* outputs.
  logic [7:0] env_mem [16];
  always @(posedge clk) begin
    if (rf_write_en === 1'b1) env_mem[rf_inSelect] <= rf_in;
  end
  assign rf_outB = env_mem[rf_outBselect];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for core, 2 stolen access cycle, 3 acknowledge
  int         m_phase = 0;
  int         m_waited = 0;
  bit         m_err = 1'b0;
  bit         m_live = 1'b0;
  bit         m_last_was_ack = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] ref_mem [16];

  logic       e_stall, e_ack, e_err, e_we, e_inc, e_dec, e_in_care;
  logic [3:0] e_isel, e_osel;
  logic [7:0] e_in;

  task automatic model_expect();
    e_stall = (m_phase != 0);
    e_ack   = (m_phase == 3);
    e_err   = (m_phase == 3) && m_err;
    if (m_phase < 2) begin
      e_isel = cpu_inSelect; e_osel = cpu_outBselect; e_in = cpu_in;
      e_we = cpu_write_en; e_inc = cpu_inc; e_dec = cpu_dec; e_in_care = 1'b1;
    end else if (m_phase == 2) begin
      e_isel = dbg_addr; e_osel = dbg_addr; e_in = dbg_we ? dbg_wdata : 8'h00;
      e_we = dbg_we; e_inc = 1'b0; e_dec = 1'b0; e_in_care = 1'b1;
    end else begin
      e_isel = dbg_addr; e_osel = dbg_addr; e_in = 8'h00;
      e_we = 1'b0; e_inc = 1'b0; e_dec = 1'b0; e_in_care = 1'b0;
    end
  endtask

  task automatic check_outputs();
    if (m_live) begin
      chk("stall", stall, e_stall);
      chk("dbg_ack", dbg_ack, e_ack);
      chk("dbg_err", dbg_err, e_err);
      chk("dbg_rdata", dbg_rdata, m_rdata);
      chk("rf_inSelect", rf_inSelect, e_isel);
      chk("rf_outBselect", rf_outBselect, e_osel);
      chk("rf_write_en", rf_write_en, e_we);
      chk("rf_inc", rf_inc, e_inc);
      chk("rf_dec", rf_dec, e_dec);
      if (e_in_care) chk("rf_in", rf_in, e_in);
    end
  endtask

  task automatic model_step();
    logic [7:0] rd;
    rd = ref_mem[dbg_addr];          // value before this cycle's write
    if (e_we === 1'b1) ref_mem[e_isel] = e_in;
    m_last_was_ack = (m_phase == 3);
    if (!rst_n) begin
      m_phase = 0; m_waited = 0; m_err = 1'b0; m_rdata = 8'h00; m_live = 1'b1;
    end else begin
      case (m_phase)
        0: if (dbg_req) begin m_phase = 1; m_waited = 0; end
        1: begin
          m_waited++;                // WAIT cycles spent so far, this one included
          if (!dbg_req) m_phase = 0;
          else if (cpu_stalled) m_phase = 2;
          else if (LIMIT != 0 && m_waited >= LIMIT) begin m_phase = 3; m_err = 1'b1; end
        end
        2: begin
          if (!dbg_we) m_rdata = rd;
          m_phase = 3; m_err = 1'b0;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: compare at the falling edge, advance model, return 2 time
  // units after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    model_expect();
    check_outputs();
    model_step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed transaction helper ----------------
  logic       we_seen [40];
  logic       inc_seen [40];
  logic [3:0] isel_seen [40];
  logic [3:0] osel_seen [40];
  logic [7:0] in_seen [40];

  task automatic txn(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                     input int stl_at, output int ack_cyc, output logic err_o,
                     output logic [7:0] rdata_o);
    ack_cyc = -1; err_o = 1'b0; rdata_o = 8'h00;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    for (int c = 0; c < 40; c++) begin
      cpu_stalled = (stl_at >= 0) && (c >= stl_at);
      #1;
      we_seen[c] = rf_write_en; inc_seen[c] = rf_inc;
      isel_seen[c] = rf_inSelect; osel_seen[c] = rf_outBselect; in_seen[c] = rf_in;
      if (dbg_ack === 1'b1) begin ack_cyc = c; err_o = dbg_err; rdata_o = dbg_rdata; end
      cycle();
      if (ack_cyc >= 0) break;
    end
    dbg_req = 1'b0;
    cpu_stalled = 1'b0;
  endtask

  initial begin
    int         ac;
    logic       er;
    logic [7:0] rd;
    int         pct;
    int         wsum;

    // ---- reset ----
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_ack", dbg_ack, 1'b0);
    chk("reset_err", dbg_err, 1'b0);
    chk("reset_rdata", dbg_rdata, 8'h00);

    // ---- preload all registers through pass-through, r9 = 3C ----
    for (int i = 0; i < 16; i++) begin
      cpu_inSelect = 4'(i);
      cpu_in = (i == 9) ? 8'h3C : 8'($urandom_range(0, 255));
      cpu_write_en = 1'b1;
      cycle();
    end
    cpu_write_en = 1'b0;

    // ---- 1: write r5 = A5 with core already stalled ----
    txn(1'b1, 4'd5, 8'hA5, 0, ac, er, rd);
    chk("t1_ack_cycle", 8'(ac), 8'd3);
    chk("t1_err", er, 1'b0);
    chk("t1_access_we", we_seen[2], 1'b1);
    chk("t1_access_isel", isel_seen[2], 4'd5);
    chk("t1_access_in", in_seen[2], 8'hA5);
    chk("t1_wait_we", we_seen[1], 1'b0);

    // ---- 2: read r9 ----
    txn(1'b0, 4'd9, 8'h00, 0, ac, er, rd);
    chk("t2_ack_cycle", 8'(ac), 8'd3);
    chk("t2_access_osel", osel_seen[2], 4'd9);
    chk("t2_access_we", we_seen[2], 1'b0);
    chk("t2_rdata_at_ack", rd, 8'h3C);

    // ---- 3: read data holds through idle ----
    for (int i = 0; i < 5; i++) cycle();
    #1;
    chk("t3_rdata_hold", dbg_rdata, 8'h3C);

    // ---- 4: core quiesces 6 cycles after stall, inc/dec held high ----
    cpu_inc = 1'b1; cpu_dec = 1'b1;
    txn(1'b1, 4'd2, 8'h77, 7, ac, er, rd);
    chk("t4_ack_cycle", 8'(ac), 8'd9);
    chk("t4_err", er, 1'b0);
    chk("t4_wait_inc_fwd", inc_seen[7], 1'b1);
    chk("t4_access_inc", inc_seen[8], 1'b0);
    chk("t4_access_we", we_seen[8], 1'b1);
    chk("t4_rdata_kept", rd, 8'h3C);
    cpu_inc = 1'b0; cpu_dec = 1'b0;

    // readback of r5 written in test 1
    txn(1'b0, 4'd5, 8'h00, 0, ac, er, rd);
    chk("t1_readback", rd, 8'hA5);

    // ---- 5: timeout, core never stalls ----
    txn(1'b1, 4'd4, 8'hEE, -1, ac, er, rd);
    chk("t5_ack_cycle", 8'(ac), 8'(LIMIT + 1));
    chk("t5_err", er, 1'b1);
    wsum = 0;
    for (int c = 0; c < 40; c++) if (c <= ac && we_seen[c] === 1'b1) wsum++;
    chk("t5_no_write", 8'(wsum), 8'd0);
    chk("t5_rdata_kept", rd, 8'hA5);

    // ---- 6: abort while waiting ----
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd7; dbg_wdata = 8'h55;
    cycle(); cycle();
    dbg_req = 1'b0;
    #1;
    chk("t6_wait_stall", stall, 1'b1);
    cycle();
    #1;
    chk("t6_idle_stall", stall, 1'b0);
    chk("t6_no_ack", dbg_ack, 1'b0);

    // ---- 7: reset during ACK ----
    cpu_stalled = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd6; dbg_wdata = 8'h11;
    cycle(); cycle(); cycle();
    #1;
    chk("t7_in_ack", dbg_ack, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; dbg_req = 1'b0; cpu_stalled = 1'b0;
    cpu_inSelect = 4'hB; cpu_outBselect = 4'h3; cpu_in = 8'h5A;
    cpu_write_en = 1'b0; cpu_inc = 1'b1;
    #1;
    chk("t7_stall", stall, 1'b0);
    chk("t7_ack", dbg_ack, 1'b0);
    chk("t7_err", dbg_err, 1'b0);
    chk("t7_rdata", dbg_rdata, 8'h00);
    chk("t7_pass_isel", rf_inSelect, 4'hB);
    chk("t7_pass_osel", rf_outBselect, 4'h3);
    chk("t7_pass_inc", rf_inc, 1'b1);
    cycle();
    cpu_inc = 1'b0;

    // ---- randomized traffic against the model ----
    pct = 100;
    for (int n = 0; n < 4000; n++) begin
      if (!dbg_req) begin
        if ($urandom_range(0, 3) == 0) begin
          dbg_req = 1'b1;
          dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = 4'($urandom_range(0, 15));
          dbg_wdata = 8'($urandom_range(0, 255));
          case ($urandom_range(0, 2))
            0: pct = 0;
            1: pct = 40;
            default: pct = 100;
          endcase
        end
      end else if (m_last_was_ack) begin
        if ($urandom_range(0, 3) != 0) dbg_req = 1'b0;   // else back-to-back
      end else if (m_phase == 1 && $urandom_range(0, 29) == 0) begin
        dbg_req = 1'b0;                                   // abort
      end
      cpu_stalled = ($urandom_range(0, 99) < pct);
      cpu_inSelect = 4'($urandom_range(0, 15));
      cpu_outBselect = 4'($urandom_range(0, 15));
      cpu_in = 8'($urandom_range(0, 255));
      cpu_write_en = ($urandom_range(0, 2) == 0);
      cpu_inc = 1'($urandom_range(0, 1));
      cpu_dec = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 249) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
